// File: rtl/serial_tx_arbiter.sv
// Shares one UART byte channel between control bytes and FIFO words (MSB byte first).
// Define SYNC_HEADER_EN to prefix every FIFO word with an 8'hA5 sync byte.
module serial_tx_arbiter #(
  parameter int WORD_W     = 48,
  parameter int FIFO_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_valid,
  input  logic [7:0]        ctrl_data,
  output logic              ctrl_ack,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [WORD_W-1:0] fifo_dout,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic              arb_busy,
  output logic [15:0]       words_sent
);

  localparam int NBYTES = WORD_W / 8;
  localparam int IW     = $clog2(NBYTES + 1) + 1;
  localparam int BW     = $clog2(FIFO_BURST + 1);

`ifdef SYNC_HEADER_EN
  typedef enum logic [2:0] {
    IDLE, CTRL_SEND, FIFO_RD, FIFO_LATCH,
    HDR_SEND, BYTE_SEND, BYTE_GAP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, CTRL_SEND, FIFO_RD, FIFO_LATCH,
    BYTE_SEND, BYTE_GAP
  } state_t;
`endif

  localparam logic PTR_CTRL = 1'b0;
  localparam logic PTR_FIFO = 1'b1;

  state_t            state;
  logic              rr_ptr;
  logic              pkt_ctrl;
  logic [BW-1:0]     burst_cnt;
  logic [IW-1:0]     byte_idx;
  logic [WORD_W-1:0] shreg;

  logic grant_ctrl;
  assign grant_ctrl = ctrl_valid &&
    (fifo_empty || rr_ptr == PTR_CTRL ||
     burst_cnt == BW'(FIFO_BURST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= PTR_CTRL;
      pkt_ctrl    <= 1'b0;
      burst_cnt   <= '0;
      byte_idx    <= '0;
      shreg       <= '0;
      ctrl_ack    <= 1'b0;
      fifo_rd_en  <= 1'b0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      arb_busy    <= 1'b0;
      words_sent  <= '0;
    end else begin
      new_tx_data <= 1'b0;
      ctrl_ack    <= 1'b0;
      fifo_rd_en  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!ctrl_valid)
            burst_cnt <= '0;
          if (grant_ctrl) begin
            // ctrl byte is captured at grant so a dropped request still sends it
            shreg    <= {ctrl_data, {(WORD_W-8){1'b0}}};
            pkt_ctrl <= 1'b1;
            arb_busy <= 1'b1;
            state    <= CTRL_SEND;
          end else if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            pkt_ctrl   <= 1'b0;
            arb_busy   <= 1'b1;
            state      <= FIFO_RD;
          end
        end
        CTRL_SEND: begin
          if (!tx_busy && !new_tx_data) begin
            tx_data     <= shreg[WORD_W-1 -: 8];
            new_tx_data <= 1'b1;
            ctrl_ack    <= 1'b1;
            rr_ptr      <= PTR_FIFO;
            burst_cnt   <= '0;
            state       <= BYTE_GAP;
          end
        end
        FIFO_RD: state <= FIFO_LATCH;
        FIFO_LATCH: begin
          shreg    <= fifo_dout;
          byte_idx <= IW'(NBYTES - 1);
`ifdef SYNC_HEADER_EN
          state    <= HDR_SEND;
`else
          state    <= BYTE_SEND;
`endif
        end
`ifdef SYNC_HEADER_EN
        HDR_SEND: begin
          if (!tx_busy) begin
            tx_data     <= 8'hA5;
            new_tx_data <= 1'b1;
            state       <= BYTE_GAP;
          end
        end
`endif
        BYTE_SEND: begin
          if (!tx_busy) begin
            tx_data     <= shreg[WORD_W-1 -: 8];
            new_tx_data <= 1'b1;
            shreg       <= shreg << 8;
            byte_idx    <= byte_idx - 1'b1;
            state       <= BYTE_GAP;
          end
        end
        BYTE_GAP: begin
          // byte_idx MSB set means the index wrapped below zero
          if (pkt_ctrl) begin
            pkt_ctrl <= 1'b0;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end else if (byte_idx[IW-1]) begin
            words_sent <= words_sent + 16'd1;
            if (burst_cnt != BW'(FIFO_BURST))
              burst_cnt <= burst_cnt + 1'b1;
            rr_ptr   <= PTR_CTRL;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= BYTE_SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: randomized ctrl/FIFO traffic and UART stalls.
// Build with SYNC_HEADER_EN defined to expect the 8'hA5 word header.
module tb_serial_tx_arbiter;

  localparam int WORD_W = 48;
  localparam int NBYTES = WORD_W / 8;
`ifdef SYNC_HEADER_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif
  localparam int PKT = NBYTES + HB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ctrl_valid = 1'b0;
  logic [7:0]        ctrl_data = '0;
  logic              ctrl_ack;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd_en;
  logic [WORD_W-1:0] fifo_dout = '0;
  logic [7:0]        tx_data;
  logic              new_tx_data;
  logic              tx_busy = 1'b0;
  logic              arb_busy;
  logic [15:0]       words_sent;

  serial_tx_arbiter #(.WORD_W(WORD_W), .FIFO_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .ctrl_valid(ctrl_valid), .ctrl_data(ctrl_data), .ctrl_ack(ctrl_ack),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .arb_busy(arb_busy), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] fifo_q[$];
  logic [7:0]        exp_fifo[$];
  logic [7:0]        exp_ctrl[$];
  logic [7:0]        ctrl_src[$];

  int busy_cnt = 0;
  bit block = 1'b0;
  bit prev_strobe = 1'b0;
  bit prev_rd = 1'b0;
  int fbytes = 0;
  int words_mdl = 0;
  int started_pend = 0;
  int strobes = 0;
  int rd_pulses = 0;
  int words_pushed = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [WORD_W-1:0] w);
    fifo_q.push_back(w);
    if (HB == 1) exp_fifo.push_back(8'hA5);
    for (int i = NBYTES - 1; i >= 0; i--)
      exp_fifo.push_back(w[i*8 +: 8]);
    words_pushed++;
  endtask

  // Monitor, FIFO model, UART busy model and ctrl requester
  always @(negedge clk) begin
    if (!rst) begin
      if (new_tx_data) begin
        strobes++;
        chk("busy_at_strobe", tx_busy, 0);
        chk("strobe_spacing", prev_strobe, 0);
        if (ctrl_ack) begin
          chk("ctrl_at_boundary", fbytes % PKT, 0);
          chk("ctrl_latency", started_pend <= 1, 1);
          if (exp_ctrl.size() == 0) chk("ctrl_unexpected", tx_data, 0);
          else chk("ctrl_byte", tx_data, exp_ctrl.pop_front());
        end else begin
          if (fbytes % PKT == 0) begin
            chk("words_sent", words_sent, 64'(words_mdl[15:0]));
            if (ctrl_valid) started_pend++;
          end
          if (exp_fifo.size() == 0) chk("fifo_unexpected", tx_data, 0);
          else chk("fifo_byte", tx_data, exp_fifo.pop_front());
          fbytes++;
          if (fbytes % PKT == 0) words_mdl++;
        end
      end else if (ctrl_ack) begin
        chk("ack_without_strobe", ctrl_ack, 0);
      end
      prev_strobe = new_tx_data;

      if (fifo_rd_en) begin
        chk("rd_when_empty", fifo_empty, 0);
        chk("rd_pulse_width", prev_rd, 0);
        rd_pulses++;
        if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      end
      prev_rd = fifo_rd_en;
      fifo_empty = (fifo_q.size() == 0);

      if (new_tx_data) busy_cnt = $urandom_range(0, 3);
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = block || (busy_cnt != 0);

      if (ctrl_ack) ctrl_valid = 1'b0;
      if (!ctrl_valid && ctrl_src.size() > 0) begin
        ctrl_data = ctrl_src.pop_front();
        exp_ctrl.push_back(ctrl_data);
        ctrl_valid = 1'b1;
        started_pend = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 20000) begin
      tick();
      n++;
      if (fifo_q.size() == 0 && ctrl_src.size() == 0 && !ctrl_valid &&
          !arb_busy && fifo_empty)
        quiet++;
      else
        quiet = 0;
    end
    chk("drain_timeout", quiet >= 4, 1);
    chk("fifo_bytes_left", exp_fifo.size(), 0);
    chk("ctrl_bytes_left", exp_ctrl.size(), 0);
  endtask

  task automatic wait_strobes(input int target);
    int n = 0;
    while (strobes < target && n < 5000) begin
      tick();
      n++;
    end
    chk("strobe_timeout", strobes >= target, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_new_tx_data", new_tx_data, 0);
    chk("rst_ctrl_ack", ctrl_ack, 0);
    chk("rst_fifo_rd_en", fifo_rd_en, 0);
    chk("rst_arb_busy", arb_busy, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_words_sent", words_sent, 0);
  endtask

  initial begin
    int base;
    int s0;
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // single control byte
    ctrl_src.push_back(8'h5A);
    wait_idle();
    chk("t1_strobes", strobes, 1);
    chk("t1_arb_busy", arb_busy, 0);

    // single word MSB first
    push_word(48'h0123456789AB);
    wait_idle();
    chk("t2_words_sent", words_sent, 1);
    chk("t2_rd_pulses", rd_pulses, 1);
    chk("t2_strobes", strobes, 1 + PKT);

    // long UART stall mid-word
    push_word(48'hDEADBEEFCAFE);
    base = strobes;
    wait_strobes(base + 2);
    block = 1'b1;
    tick();
    s0 = strobes;
    repeat (100) tick();
    chk("t4_no_strobe_busy", strobes - s0, 0);
    block = 1'b0;
    wait_idle();
    chk("t4_words_sent", words_sent, 2);

    // ten words against a held stream of control bytes
    for (int i = 0; i < 10; i++)
      push_word({$urandom, $urandom} & {WORD_W{1'b1}});
    for (int i = 0; i < 5; i++)
      ctrl_src.push_back(8'($urandom));
    wait_idle();
    chk("t3_words_sent", words_sent, 12);

    // randomized traffic with random stalls
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0)
        push_word({$urandom, $urandom} & {WORD_W{1'b1}});
      if ($urandom_range(0, 20) == 0)
        ctrl_src.push_back(8'($urandom));
      if ($urandom_range(0, 30) == 0)
        block = ~block;
      tick();
    end
    block = 1'b0;
    wait_idle();
    chk("rand_words_sent", words_sent, 64'(words_mdl[15:0]));
    chk("rand_rd_pulses", rd_pulses, words_pushed);

    // reset after the third byte of a word
    push_word(48'h112233445566);
    base = strobes;
    wait_strobes(base + 3);
    rst = 1'b1;
    tick();
    check_reset_outputs();
    exp_fifo.delete();
    fbytes = 0;
    words_mdl = 0;
    prev_strobe = 1'b0;
    prev_rd = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("t5_no_reread", rd_pulses, words_pushed);

    // all-ones word after reset starts at its MSB byte
    push_word(48'hFFFFFFFFFFFF);
    wait_idle();
    chk("t6_words_sent", words_sent, 1);
    chk("t6_rd_pulses", rd_pulses, words_pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
